// File: rtl/fp_rx_pkg.sv
// Shared definitions for the floating-point result receiver:
// default result width, IEEE-754 double field widths and a NaN classifier.
package fp_rx_pkg;

  localparam int DW_DEFAULT = 64;
  localparam int EXP_W      = 11;
  localparam int MAN_W      = 52;

  typedef struct packed {
    logic             sign_f;
    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
  } fp64_t;

  // NaN: exponent all ones and a non-zero mantissa (infinity has a zero mantissa).
  function automatic logic is_nan_f64(input fp64_t v);
    return (&v.exp_f) && (|v.man_f);
  endfunction

endpackage

// File: rtl/fp_rx_sync_fifo.sv
// Small in-order register FIFO with first-word fall-through read port.
// Push is ignored when full and pop is ignored when empty, so callers may
// drive raw handshake terms. DEPTH must be a power of two (natural pointer wrap).
module fp_rx_sync_fifo
  import fp_rx_pkg::*;
#(
  parameter int W     = DW_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rdata     = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Data array write; contents are only meaningful below the occupancy count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fp_axis_result_rx.sv
// Receive side of the floating-point IP: buffers AXIS results in an in-order
// FIFO, re-presents them on a valid/ready port and grants issue credits so the
// IP never owes more results than the FIFO can hold.
// Optional build macro FP_RX_NAN_CHECK_EN adds a per-entry NaN flag (DW must be 64).
module fp_axis_result_rx
  import fp_rx_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue,
  output logic                         issue_ok,
  input  logic                         s_axis_result_tvalid,
  output logic                         s_axis_result_tready,
  input  logic [DW-1:0]                s_axis_result_tdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DW-1:0]                out_data,
  output logic                         out_nan,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding,
  output logic                         err
);

  localparam int CW = $clog2(DEPTH+1);
`ifdef FP_RX_NAN_CHECK_EN
  localparam int FW = DW + 1;
`else
  localparam int FW = DW;
`endif

  logic [FW-1:0] fifo_wdata_s;
  logic [FW-1:0] fifo_rdata_s;
  logic [DW-1:0] head_data_s;
  logic          head_nan_s;
  logic          full_s;
  logic          empty_s;
  logic [CW-1:0] count_s;
  logic          push_s;
  logic          pop_s;
  logic          issue_acc_s;
  logic          issue_bad_s;
  logic          unsolicited_s;
  logic [CW-1:0] outstanding_r;
  logic          err_r;

  // Every output is held low while reset is asserted.
  assign s_axis_result_tready = !rst && !full_s;
  assign out_valid            = !rst && !empty_s;
  assign issue_ok             = !rst && (outstanding_r < CW'(DEPTH));
  assign out_data             = rst ? {DW{1'b0}} : head_data_s;
  assign out_nan              = !rst && head_nan_s;
  assign outstanding          = rst ? {CW{1'b0}} : outstanding_r;
  assign err                  = !rst && err_r;

  assign push_s        = s_axis_result_tvalid && s_axis_result_tready;
  assign pop_s         = out_valid && out_ready;
  assign issue_acc_s   = issue && issue_ok;
  assign issue_bad_s   = issue && !issue_ok;
  // The IP owes outstanding - count results; a push with nothing owed is unsolicited.
  assign unsolicited_s = push_s && (outstanding_r <= count_s);

`ifdef FP_RX_NAN_CHECK_EN
  fp64_t push_fp_s;
  assign push_fp_s    = s_axis_result_tdata;
  assign fifo_wdata_s = {is_nan_f64(push_fp_s), s_axis_result_tdata};
  assign head_nan_s   = fifo_rdata_s[DW];
`else
  assign fifo_wdata_s = s_axis_result_tdata;
  assign head_nan_s   = 1'b0;
`endif
  assign head_data_s = fifo_rdata_s[DW-1:0];

  fp_rx_sync_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (fifo_wdata_s),
    .rdata (fifo_rdata_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Credit counter: +1 per accepted issue, -1 per consumer pop, floor at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_r <= {CW{1'b0}};
    end else begin
      case ({issue_acc_s, pop_s})
        2'b10:   outstanding_r <= outstanding_r + CW'(1);
        2'b01:   outstanding_r <= (outstanding_r != {CW{1'b0}}) ? outstanding_r - CW'(1)
                                                                : outstanding_r;
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  // Sticky protocol error: issue without credit or a result nobody asked for.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (issue_bad_s || unsolicited_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

endmodule

// File: tb/tb_fp_axis_result_rx.sv
// Self-checking bench for fp_axis_result_rx: a directed vector table, an
// in-order wrap sequence and constrained-random traffic against a queue model.
module tb_fp_axis_result_rx;

  localparam int DW    = 64;
  localparam int DEPTH = 4;
`ifdef FP_RX_NAN_CHECK_EN
  localparam bit NAN_EN = 1'b1;
`else
  localparam bit NAN_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue = 1'b0;
  logic          issue_ok;
  logic          tvalid = 1'b0;
  logic          tready;
  logic [DW-1:0] tdata = 64'd0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_nan;
  logic [2:0]    outstanding;
  logic          err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_axis_result_rx #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .issue                (issue),
    .issue_ok             (issue_ok),
    .s_axis_result_tvalid (tvalid),
    .s_axis_result_tready (tready),
    .s_axis_result_tdata  (tdata),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_data             (out_data),
    .out_nan              (out_nan),
    .outstanding          (outstanding),
    .err                  (err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit ref_nan(input logic [63:0] v);
    return (v[62:52] == 11'h7FF) && (v[51:0] != 52'd0);
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst, iss, tv, ordy;
    logic [63:0] td;
    bit          e_v;
    logic [63:0] e_d;
    bit          e_nan, e_tr, e_ok;
    int          e_o;
    bit          e_err;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit r, bit i, bit tv, logic [63:0] td, bit o,
                              bit ev, logic [63:0] ed, bit en, bit etr, bit eok,
                              int eo, bit ee);
    vec_t v;
    v.rst = r; v.iss = i; v.tv = tv; v.td = td; v.ordy = o;
    v.e_v = ev; v.e_d = ed; v.e_nan = en; v.e_tr = etr; v.e_ok = eok;
    v.e_o = eo; v.e_err = ee;
    tbl.push_back(v);
  endfunction

  // ---------------- behavioural model ----------------
  logic [63:0] mq[$];
  int          m_out;
  bit          m_err;

  task automatic model_clear();
    mq.delete();
    m_out = 0;
    m_err = 1'b0;
  endtask

  task automatic mstep(input bit iss, input bit tv, input logic [63:0] td, input bit ordy);
    int  cnt;
    bit  push, pop, ok;
    cnt  = mq.size();
    ok   = (m_out < DEPTH);
    push = tv && (cnt < DEPTH);
    pop  = ordy && (cnt > 0);
    if (iss && !ok) m_err = 1'b1;
    if (push && (m_out - cnt <= 0)) m_err = 1'b1;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(td);
    if (iss && ok) m_out++;
    if (pop && m_out > 0) m_out--;
    issue = iss; tvalid = tv; tdata = td; out_ready = ordy;
    @(posedge clk); #1;
    chk("m.valid", 64'(out_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("m.data", out_data, mq[0]);
      chk("m.nan", 64'(out_nan), 64'(NAN_EN && ref_nan(mq[0])));
    end
    chk("m.tready", 64'(tready), 64'(mq.size() < DEPTH));
    chk("m.issue_ok", 64'(issue_ok), 64'(m_out < DEPTH));
    chk("m.outstanding", 64'(outstanding), 64'(m_out));
    chk("m.err", 64'(err), 64'(m_err));
  endtask

  task automatic do_reset();
    rst = 1'b1; issue = 1'b0; tvalid = 1'b0; out_ready = 1'b0; tdata = 64'd0;
    @(posedge clk); #1;
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.tready", 64'(tready), 64'd0);
    chk("rst.issue_ok", 64'(issue_ok), 64'd0);
    chk("rst.err", 64'(err), 64'd0);
    rst = 1'b0;
    model_clear();
  endtask

  logic [63:0] dut_popped[$];

  initial begin
    logic [63:0] z, d1, n1, n2;
    z  = 64'h0;
    d1 = 64'h4008000000000000;
    n1 = 64'h7FF8000000000000;
    n2 = 64'h7FF0000000000000;

    // Reset and a single operation with five cycles of IP latency.
    add(1,0,0,z,0, 0,z,0, 0,0,0,0);
    add(0,0,0,z,0, 0,z,0, 1,1,0,0);
    add(0,1,0,z,0, 0,z,0, 1,1,1,0);
    for (int k = 0; k < 4; k++) add(0,0,0,z,0, 0,z,0, 1,1,1,0);
    add(0,0,1,d1,0, 1,d1,0, 1,1,1,0);
    add(0,0,0,z,1, 0,z,0, 1,1,0,0);
    // Credit exhaustion, then an issue without credit.
    for (int k = 1; k <= 4; k++) add(0,1,0,z,0, 0,z,0, 1,(k < 4),k,0);
    add(0,1,0,z,0, 0,z,0, 1,0,4,1);
    // Backpressure: fill, hold a fifth result until a pop frees a slot.
    add(1,0,0,z,0, 0,z,0, 0,0,0,0);
    for (int k = 1; k <= 4; k++) add(0,1,0,z,0, 0,z,0, 1,(k < 4),k,0);
    for (int k = 1; k <= 4; k++) add(0,0,1,64'(k),0, 1,64'd1,0, (k < 4),0,4,0);
    add(0,0,1,64'd5,0, 1,64'd1,0, 0,0,4,0);
    add(0,0,1,64'd5,1, 1,64'd2,0, 1,1,3,0);
    add(0,0,1,64'd5,0, 1,64'd2,0, 0,1,3,1);
    add(0,0,0,z,1, 1,64'd3,0, 1,1,2,1);
    add(0,0,0,z,1, 1,64'd4,0, 1,1,1,1);
    add(0,0,0,z,1, 1,64'd5,0, 1,1,0,1);
    // Unsolicited result, then reset clears the FIFO and the error.
    add(1,0,0,z,0, 0,z,0, 0,0,0,0);
    add(0,0,1,64'hABCD,0, 1,64'hABCD,0, 1,1,0,1);
    add(1,0,0,z,0, 0,z,0, 0,0,0,0);
    add(0,0,0,z,0, 0,z,0, 1,1,0,0);
    // NaN flag follows the head entry.
    add(0,1,0,z,0, 0,z,0, 1,1,1,0);
    add(0,1,0,z,0, 0,z,0, 1,1,2,0);
    add(0,0,1,n1,0, 1,n1,NAN_EN, 1,1,2,0);
    add(0,0,1,n2,0, 1,n1,NAN_EN, 1,1,2,0);
    add(0,0,0,z,1, 1,n2,0, 1,1,1,0);
    add(0,0,0,z,1, 0,z,0, 1,1,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; issue = tbl[i].iss; tvalid = tbl[i].tv;
      tdata = tbl[i].td; out_ready = tbl[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("tbl[%0d].valid", i), 64'(out_valid), 64'(tbl[i].e_v));
      if (tbl[i].e_v || tbl[i].rst) begin
        chk($sformatf("tbl[%0d].data", i), out_data, tbl[i].e_d);
        chk($sformatf("tbl[%0d].nan", i), 64'(out_nan), 64'(tbl[i].e_nan));
      end
      chk($sformatf("tbl[%0d].tready", i), 64'(tready), 64'(tbl[i].e_tr));
      chk($sformatf("tbl[%0d].issue_ok", i), 64'(issue_ok), 64'(tbl[i].e_ok));
      chk($sformatf("tbl[%0d].outstanding", i), 64'(outstanding), 64'(tbl[i].e_o));
      chk($sformatf("tbl[%0d].err", i), 64'(err), 64'(tbl[i].e_err));
    end

    // Wrap: 20 operations, one result per cycle when owed, out_ready toggling.
    do_reset();
    begin
      int issued, returned, cyc;
      bit iss, tv, ordy;
      issued = 0; returned = 0; cyc = 0;
      dut_popped.delete();
      while (dut_popped.size() < 20 && cyc < 300) begin
        iss  = (issued < 20) && (m_out < DEPTH);
        tv   = (returned < 20) && (m_out - mq.size() > 0);
        ordy = (cyc % 2 == 0);
        if (out_valid && ordy) dut_popped.push_back(out_data);
        if (tv && mq.size() < DEPTH) returned++;
        if (iss) issued++;
        mstep(iss, tv, 64'(returned), ordy);
        cyc++;
      end
      chk("wrap.count", 64'(dut_popped.size()), 64'd20);
      for (int k = 0; k < dut_popped.size(); k++)
        chk($sformatf("wrap.order[%0d]", k), dut_popped[k], 64'(k + 1));
    end

    // Constrained-random legal traffic against the queue model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bit          iss, tv, ordy;
      logic [63:0] td;
      iss  = (m_out < DEPTH) && ($urandom_range(0, 1) == 1);
      tv   = (m_out - mq.size() > 0) && ($urandom_range(0, 2) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      td   = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) td[62:52] = 11'h7FF;
      mstep(iss, tv, td, ordy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_axis_result_rx.md
Name: fp_axis_result_rx

Overview:
- Receive-side companion to the pulse-to-AXIS operand issuer in front of the floating-point IP (multiplier, adder, etc.).
- Accepts the IP's AXIS result stream with real tready backpressure and buffers results in a small in-order FIFO.
- Re-presents results to the consumer on a valid/ready port.
- Grants issue credits so the upstream issuer never has more operations in flight than the FIFO can absorb. This makes it safe to stall the consumer.

Parameters:
- DW, 64, result width in bits (IEEE-754 double by default).
- DEPTH, 4, FIFO entries and maximum outstanding operations; power of two, at least 2.

Ports:
- clk  in  1  Clock.
- rst  in  1  Synchronous, active-high reset.
- issue  in  1  Pulse: the issuer handed one operand pair to the IP this cycle.
- issue_ok  out  1  Credit available; issuer may only pulse issue while high.
- s_axis_result_tvalid  in  1  IP result valid.
- s_axis_result_tready  out  1  Ready for an IP result.
- s_axis_result_tdata  in  DW  IP result data.
- out_valid  out  1  Buffered result available.
- out_ready  in  1  Consumer accepts the result.
- out_data  out  DW  Head-of-FIFO result.
- out_nan  out  1  Head result is NaN (optional feature).
- outstanding  out  $clog2(DEPTH+1)  Issued but not yet popped count.
- err  out  1  Sticky protocol-error flag.

Behaviour:
- Reset: synchronous. While rst is high, every output is driven low, including s_axis_result_tready. The first cycle after release shows:
  - pointers 0, count 0, outstanding 0
  - s_axis_result_tready 1, issue_ok 1, out_valid 0, err 0
- FIFO: DEPTH-entry register array with wrapping rd_ptr/wr_ptr and an occupancy count 0..DEPTH.
  - s_axis_result_tready = !full, combinational.
  - Push when s_axis_result_tvalid && s_axis_result_tready.
  - Pop when out_valid && out_ready.
  - out_valid = !empty; out_data = mem[rd_ptr], first-word fall-through.
  - Latency: a pushed result is visible on out_valid the next cycle. There is no same-cycle bypass.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - When full, tready is 0, so no push occurs even if a pop happens that cycle.
  - When empty, out_valid is 0, so no pop occurs; the push lands.
- Pointer wrap: log2(DEPTH) bits, natural modulo wrap from DEPTH-1 to 0.
- Credit counter outstanding:
  - Increments on accepted issue (issue && issue_ok).
  - Decrements on pop.
  - Both in the same cycle: unchanged.
  - issue_ok = (outstanding < DEPTH).
- in_flight = outstanding - count = results the IP still owes. This is never negative in correct operation.
- Errors, sticky until rst:
  - issue while !issue_ok: the issue is ignored (counter not incremented) and err is set.
  - Push while in_flight == 0 (unsolicited result): the data is still stored and err is set.
- Ordering: results leave strictly in arrival order. No tags.
- Reset mid-operation: buffered data is discarded and in-flight credits are forgotten. The integration must reset the IP wrapper in the same cycle.

Optional Feature:
- Macro FP_RX_NAN_CHECK_EN.
- Defined:
  - A NaN flag is computed at push time and stored in a parallel DEPTH-bit array alongside each entry.
  - NaN means exponent bits [DW-2:DW-12] all ones and mantissa bits [DW-13:0] non-zero, for DW=64.
  - out_nan follows the head entry.
- Undefined: out_nan is tied to 0 and no flag storage is built.

Decomposition:
- Package fp_rx_pkg:
  - DW_DEFAULT=64.
  - Double-precision field constants (EXP_W=11, MAN_W=52).
  - Function is_nan_f64.
  - Typedef fp64_t.
- One natural sub-module, fp_rx_sync_fifo: parameterised DW/DEPTH register FIFO with push/pop/full/empty/count.
- The credit counter and error logic stay in the top.

Test Plan:
- Reset then single op: issue pulse at t0, IP returns 0x4008000000000000 at t5 → out_valid at t6 with that data; out_ready=1 pops; outstanding 1→0; err=0.
- Credit exhaustion, DEPTH=4: four issue pulses with out_ready=0 → issue_ok drops after the 4th; a 5th issue sets err=1 and outstanding stays 4.
- Backpressure: four results pushed with out_ready=0 → s_axis_result_tready=0 at count 4; the held 5th tvalid is not accepted until one pop; data order 1,2,3,4 preserved.
- Wrap and simultaneous traffic: 20 issues, one result per cycle, out_ready toggling 1,0,1,... → all 20 values out in order; no err.
- Unsolicited result: tvalid with outstanding=0 → entry stored, err=1; rst clears err and the FIFO.
- With FP_RX_NAN_CHECK_EN: push 0x7FF8000000000000, then 0x7FF0000000000000 → out_nan 1 then 0; macro undefined → out_nan always 0.
